// File: rtl/fwd_ctrl_if.sv
// Bundle of pipeline-control signals between the ID/EX datapath and fwd_ctrl_unit.
// The datapath side uses the master modport, the controller the slave modport.
interface fwd_ctrl_if #(
    parameter int RA_W = 3
);
    logic            mem_busy;
    logic            id_valid;
    logic [RA_W-1:0] id_rs1;
    logic [RA_W-1:0] id_rs2;
    logic            id_use_imm;
    logic            id_wr_en;
    logic [RA_W-1:0] id_rd;
    logic            id_is_load;
    logic [1:0]      sel1;
    logic [1:0]      sel2;
    logic            stall;
    logic            ex_bubble;

    modport master (
        output mem_busy, id_valid, id_rs1, id_rs2, id_use_imm,
               id_wr_en, id_rd, id_is_load,
        input  sel1, sel2, stall, ex_bubble
    );

    modport slave (
        input  mem_busy, id_valid, id_rs1, id_rs2, id_use_imm,
               id_wr_en, id_rd, id_is_load,
        output sel1, sel2, stall, ex_bubble
    );
endinterface

// File: rtl/fwd_ctrl_unit.sv
// Forwarding selects and load-use stall control for the EX-stage ALU operand muxes.
// Optional macro ZERO_REG_EN: register 0 is hardwired zero (never forwarded, never stalls).
module fwd_ctrl_unit #(
    parameter int RA_W     = 3,
    parameter int LD_STALL = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    fwd_ctrl_if.slave     bus
);

    typedef enum logic {
        ST_RUN,
        ST_HOLD
    } state_t;

    localparam logic [1:0] CNT_INIT = 2'(LD_STALL - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [1:0]      r_cnt;
    logic [1:0]      w_cnt_nxt;

    // Only EX and MEM entries feed a select; a WB producer has already written the register file.
    logic            r_ex_v;
    logic            r_ex_wr;
    logic            r_ex_ld;
    logic [RA_W-1:0] r_ex_rd;
    logic            r_mem_v;
    logic            r_mem_wr;
    logic [RA_W-1:0] r_mem_rd;

    logic [1:0]      r_sel1;
    logic [1:0]      r_sel2;

    logic            w_rs1_nz;
    logic            w_rs2_nz;
    logic            w_hit_ex1;
    logic            w_hit_ex2;
    logic            w_hit_mem1;
    logic            w_hit_mem2;
    logic            w_hazard;
    logic            w_stall;
    logic            w_issue;
    logic [1:0]      w_sel1;
    logic [1:0]      w_sel2;

`ifdef ZERO_REG_EN
    assign w_rs1_nz = |bus.id_rs1;
    assign w_rs2_nz = |bus.id_rs2;
`else
    assign w_rs1_nz = 1'b1;
    assign w_rs2_nz = 1'b1;
`endif

    assign w_hit_ex1  = r_ex_v  & r_ex_wr  & (r_ex_rd  == bus.id_rs1) & w_rs1_nz;
    assign w_hit_ex2  = r_ex_v  & r_ex_wr  & (r_ex_rd  == bus.id_rs2) & w_rs2_nz;
    assign w_hit_mem1 = r_mem_v & r_mem_wr & (r_mem_rd == bus.id_rs1) & w_rs1_nz;
    assign w_hit_mem2 = r_mem_v & r_mem_wr & (r_mem_rd == bus.id_rs2) & w_rs2_nz;

    assign w_hazard = bus.id_valid & r_ex_ld &
                      (w_hit_ex1 | (w_hit_ex2 & ~bus.id_use_imm));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_cnt   <= 2'd0;
        end else if (!bus.mem_busy) begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_RUN: begin
                if (w_hazard) begin
                    w_cnt_nxt = CNT_INIT;
                    if (CNT_INIT != 2'd0) begin
                        w_state_nxt = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                w_cnt_nxt = r_cnt - 2'd1;
                if (r_cnt == 2'd1) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    // HOLD stalls regardless of the ID contents; the load has already left EX.
    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            ST_RUN:  w_stall = w_hazard;
            ST_HOLD: w_stall = 1'b1;
            default: w_stall = 1'b0;
        endcase
    end

    assign w_issue = bus.id_valid & ~w_stall;

    // Youngest producer wins: EX beats MEM; the immediate overrides any forwarding on operand 2.
    always_comb begin
        w_sel1 = 2'd0;
        if (w_hit_ex1) begin
            w_sel1 = 2'd1;
        end else if (w_hit_mem1) begin
            w_sel1 = 2'd2;
        end
        w_sel2 = 2'd0;
        if (bus.id_use_imm) begin
            w_sel2 = 2'd3;
        end else if (w_hit_ex2) begin
            w_sel2 = 2'd1;
        end else if (w_hit_mem2) begin
            w_sel2 = 2'd2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_v   <= 1'b0;
            r_ex_wr  <= 1'b0;
            r_ex_ld  <= 1'b0;
            r_ex_rd  <= '0;
            r_mem_v  <= 1'b0;
            r_mem_wr <= 1'b0;
            r_mem_rd <= '0;
            r_sel1   <= 2'd0;
            r_sel2   <= 2'd0;
        end else if (!bus.mem_busy) begin
            r_mem_v  <= r_ex_v;
            r_mem_wr <= r_ex_wr;
            r_mem_rd <= r_ex_rd;
            if (w_issue) begin
                r_ex_v  <= 1'b1;
                r_ex_wr <= bus.id_wr_en;
                r_ex_ld <= bus.id_is_load;
                r_ex_rd <= bus.id_rd;
                r_sel1  <= w_sel1;
                r_sel2  <= w_sel2;
            end else begin
                r_ex_v  <= 1'b0;
                r_ex_wr <= 1'b0;
                r_ex_ld <= 1'b0;
                r_ex_rd <= '0;
                r_sel1  <= 2'd0;
                r_sel2  <= 2'd0;
            end
        end
    end

    assign bus.sel1      = r_sel1;
    assign bus.sel2      = r_sel2;
    assign bus.stall     = w_stall;
    assign bus.ex_bubble = ~r_ex_v;

endmodule

// File: tb/tb_fwd_ctrl_unit.sv
// Bench for fwd_ctrl_unit: three instances (LD_STALL = 1, 2, 3) share one ID stream.
// Directed scenarios check constants; a random phase checks against a pipeline-queue model.
module tb_fwd_ctrl_unit;

    localparam int RA_W = 3;
    localparam int NI   = 3;

    logic clk = 1'b0;
    logic rstN;
    logic memBusy;
    logic idValid;
    logic [RA_W-1:0] idRs1;
    logic [RA_W-1:0] idRs2;
    logic idUseImm;
    logic idWrEn;
    logic [RA_W-1:0] idRd;
    logic idIsLoad;

    logic       stallO [NI];
    logic [1:0] sel1O  [NI];
    logic [1:0] sel2O  [NI];
    logic       bubO   [NI];

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    fwd_ctrl_if #(.RA_W(RA_W)) bus [NI] ();

    for (genvar g = 0; g < NI; g++) begin : g_dut
        assign bus[g].mem_busy   = memBusy;
        assign bus[g].id_valid   = idValid;
        assign bus[g].id_rs1     = idRs1;
        assign bus[g].id_rs2     = idRs2;
        assign bus[g].id_use_imm = idUseImm;
        assign bus[g].id_wr_en   = idWrEn;
        assign bus[g].id_rd      = idRd;
        assign bus[g].id_is_load = idIsLoad;
        assign stallO[g] = bus[g].stall;
        assign sel1O[g]  = bus[g].sel1;
        assign sel2O[g]  = bus[g].sel2;
        assign bubO[g]   = bus[g].ex_bubble;

        fwd_ctrl_unit #(.RA_W(RA_W), .LD_STALL(g + 1)) dut (
            .clk   (clk),
            .rst_n (rstN),
            .bus   (bus[g])
        );
    end

    // Reference model: one EX and one MEM slot per instance plus a count of stall cycles still owed.
    typedef struct packed {
        logic v;
        logic wr;
        logic ld;
        logic [RA_W-1:0] rd;
    } entry_t;

    entry_t     mEx   [NI];
    entry_t     mMem  [NI];
    int         mLeft [NI];
    logic [1:0] mSel1 [NI];
    logic [1:0] mSel2 [NI];
    logic       mBub  [NI];

    function automatic logic mHit(entry_t e, logic [RA_W-1:0] rs);
`ifdef ZERO_REG_EN
        if (rs == 0) return 1'b0;
`endif
        return e.v && e.wr && (e.rd == rs);
    endfunction

    function automatic logic mStall(int k);
        if (mLeft[k] > 0) return 1'b1;
        return idValid && mEx[k].ld &&
               (mHit(mEx[k], idRs1) || (mHit(mEx[k], idRs2) && !idUseImm));
    endfunction

    task automatic modelReset();
        for (int k = 0; k < NI; k++) begin
            mEx[k]   = '0;
            mMem[k]  = '0;
            mLeft[k] = 0;
            mSel1[k] = 2'd0;
            mSel2[k] = 2'd0;
            mBub[k]  = 1'b1;
        end
    endtask

    task automatic modelStep();
        for (int k = 0; k < NI; k++) begin
            if (!memBusy) begin
                logic st;
                logic issue;
                logic [1:0] s1;
                logic [1:0] s2;
                st    = mStall(k);
                issue = idValid && !st;
                s1 = mHit(mEx[k], idRs1) ? 2'd1 : (mHit(mMem[k], idRs1) ? 2'd2 : 2'd0);
                s2 = mHit(mEx[k], idRs2) ? 2'd1 : (mHit(mMem[k], idRs2) ? 2'd2 : 2'd0);
                if (idUseImm) s2 = 2'd3;
                if (mLeft[k] > 0) mLeft[k] = mLeft[k] - 1;
                else if (st) mLeft[k] = k;
                mMem[k] = mEx[k];
                if (issue) begin
                    mEx[k]   = '{v: 1'b1, wr: idWrEn, ld: idIsLoad, rd: idRd};
                    mSel1[k] = s1;
                    mSel2[k] = s2;
                    mBub[k]  = 1'b0;
                end else begin
                    mEx[k]   = '0;
                    mSel1[k] = 2'd0;
                    mSel2[k] = 2'd0;
                    mBub[k]  = 1'b1;
                end
            end
        end
    endtask

    task automatic setId(input logic v, input int rs1, input int rs2, input logic imm,
                         input logic wr, input int rd, input logic ld);
        idValid  = v;
        idRs1    = RA_W'(rs1);
        idRs2    = RA_W'(rs2);
        idUseImm = imm;
        idWrEn   = wr;
        idRd     = RA_W'(rd);
        idIsLoad = ld;
    endtask

    task automatic tick();
        modelStep();
        @(negedge clk);
    endtask

    task automatic doReset();
        @(negedge clk);
        rstN    = 1'b0;
        memBusy = 1'b0;
        setId(0, 0, 0, 0, 0, 0, 0);
        modelReset();
        #1;
        @(negedge clk);
        rstN = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rstN    = 1'b0;
        memBusy = 1'b0;
        setId(0, 0, 0, 0, 0, 0, 0);
        modelReset();
        #1;
        for (int k = 0; k < NI; k++) begin
            if (sel1O[k] !== 2'd0) begin nFails++; $display("[TB] FAIL reset_sel1[%0d]: got %0d expected 0", k, sel1O[k]); end
            nChecks++;
            if (sel2O[k] !== 2'd0) begin nFails++; $display("[TB] FAIL reset_sel2[%0d]: got %0d expected 0", k, sel2O[k]); end
            nChecks++;
            if (bubO[k] !== 1'b1) begin nFails++; $display("[TB] FAIL reset_bubble[%0d]: got %0d expected 1", k, bubO[k]); end
            nChecks++;
            if (stallO[k] !== 1'b0) begin nFails++; $display("[TB] FAIL reset_stall[%0d]: got %0d expected 0", k, stallO[k]); end
            nChecks++;
        end
        @(negedge clk);
        rstN = 1'b1;
    endtask

    task automatic test_forwarding();
        doReset();
        setId(1, 1, 2, 0, 1, 3, 0);
        tick();
        setId(1, 3, 5, 0, 1, 6, 0);
        #1;
        if (stallO[0] !== 1'b0) begin nFails++; $display("[TB] FAIL fwd_no_stall: got %0d expected 0", stallO[0]); end
        nChecks++;
        tick();
        if (sel1O[0] !== 2'd1) begin nFails++; $display("[TB] FAIL fwd_ex_sel1: got %0d expected 1", sel1O[0]); end
        nChecks++;
        if (bubO[0] !== 1'b0) begin nFails++; $display("[TB] FAIL fwd_ex_bubble: got %0d expected 0", bubO[0]); end
        nChecks++;
        memBusy = 1'b1;
        setId(1, 6, 6, 0, 1, 1, 0);
        tick();
        tick();
        if (sel1O[0] !== 2'd1) begin nFails++; $display("[TB] FAIL busy_sel_hold: got %0d expected 1", sel1O[0]); end
        nChecks++;
        if (bubO[0] !== 1'b0) begin nFails++; $display("[TB] FAIL busy_bubble_hold: got %0d expected 0", bubO[0]); end
        nChecks++;
        memBusy = 1'b0;
        setId(1, 4, 3, 0, 0, 0, 0);
        tick();
        if (sel2O[0] !== 2'd2) begin nFails++; $display("[TB] FAIL fwd_mem_sel2: got %0d expected 2", sel2O[0]); end
        nChecks++;
        if (sel1O[0] !== 2'd0) begin nFails++; $display("[TB] FAIL fwd_mem_sel1: got %0d expected 0", sel1O[0]); end
        nChecks++;
    endtask

    task automatic test_back_to_back();
        doReset();
        setId(1, 1, 1, 0, 1, 2, 0);
        tick();
        setId(1, 5, 5, 0, 1, 2, 0);
        tick();
        setId(1, 2, 7, 0, 0, 0, 0);
        tick();
        if (sel1O[0] !== 2'd1) begin nFails++; $display("[TB] FAIL youngest_wins: got %0d expected 1", sel1O[0]); end
        nChecks++;
    endtask

    task automatic test_load_use();
        doReset();
        setId(1, 1, 1, 0, 1, 4, 1);
        tick();
        setId(1, 5, 4, 0, 1, 6, 0);
        #1;
        for (int k = 0; k < NI; k++) begin
            if (stallO[k] !== 1'b1) begin nFails++; $display("[TB] FAIL lu_stall_c1[%0d]: got %0d expected 1", k, stallO[k]); end
            nChecks++;
        end
        tick();
        if (bubO[0] !== 1'b1) begin nFails++; $display("[TB] FAIL lu_bubble: got %0d expected 1", bubO[0]); end
        nChecks++;
        #1;
        if (stallO[0] !== 1'b0) begin nFails++; $display("[TB] FAIL lu1_stall_c2: got %0d expected 0", stallO[0]); end
        nChecks++;
        if (stallO[1] !== 1'b1) begin nFails++; $display("[TB] FAIL lu2_stall_c2: got %0d expected 1", stallO[1]); end
        nChecks++;
        tick();
        if (sel2O[0] !== 2'd2) begin nFails++; $display("[TB] FAIL lu1_sel2: got %0d expected 2", sel2O[0]); end
        nChecks++;
        if (bubO[0] !== 1'b0) begin nFails++; $display("[TB] FAIL lu1_issue: got %0d expected 0", bubO[0]); end
        nChecks++;
        #1;
        if (stallO[1] !== 1'b0) begin nFails++; $display("[TB] FAIL lu2_stall_c3: got %0d expected 0", stallO[1]); end
        nChecks++;
        if (stallO[2] !== 1'b1) begin nFails++; $display("[TB] FAIL lu3_stall_c3: got %0d expected 1", stallO[2]); end
        nChecks++;
        tick();
        if (sel2O[1] !== 2'd0) begin nFails++; $display("[TB] FAIL lu2_sel2: got %0d expected 0", sel2O[1]); end
        nChecks++;
        if (bubO[1] !== 1'b0) begin nFails++; $display("[TB] FAIL lu2_issue: got %0d expected 0", bubO[1]); end
        nChecks++;
    endtask

    task automatic test_busy_hold();
        doReset();
        setId(1, 1, 1, 0, 1, 4, 1);
        tick();
        setId(1, 1, 4, 0, 1, 6, 0);
        tick();
        memBusy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (stallO[2] !== 1'b1) begin nFails++; $display("[TB] FAIL busy_stall[%0d]: got %0d expected 1", c, stallO[2]); end
            nChecks++;
            if (bubO[2] !== 1'b1) begin nFails++; $display("[TB] FAIL busy_bubble[%0d]: got %0d expected 1", c, bubO[2]); end
            nChecks++;
            tick();
        end
        memBusy = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            if (stallO[2] !== 1'b1) begin nFails++; $display("[TB] FAIL resume_stall[%0d]: got %0d expected 1", c, stallO[2]); end
            nChecks++;
            tick();
        end
        #1;
        if (stallO[2] !== 1'b0) begin nFails++; $display("[TB] FAIL resume_end: got %0d expected 0", stallO[2]); end
        nChecks++;
        tick();
        if (bubO[2] !== 1'b0) begin nFails++; $display("[TB] FAIL resume_issue: got %0d expected 0", bubO[2]); end
        nChecks++;
    endtask

    task automatic test_busy_hazard();
        doReset();
        setId(1, 1, 1, 0, 1, 4, 1);
        tick();
        setId(1, 4, 2, 0, 1, 6, 0);
        memBusy = 1'b1;
        #1;
        if (stallO[0] !== 1'b1) begin nFails++; $display("[TB] FAIL bh_stall_busy: got %0d expected 1", stallO[0]); end
        nChecks++;
        tick();
        if (bubO[0] !== 1'b0) begin nFails++; $display("[TB] FAIL bh_load_held: got %0d expected 0", bubO[0]); end
        nChecks++;
        memBusy = 1'b0;
        #1;
        if (stallO[0] !== 1'b1) begin nFails++; $display("[TB] FAIL bh_stall_after: got %0d expected 1", stallO[0]); end
        nChecks++;
        tick();
        tick();
        if (sel1O[0] !== 2'd2) begin nFails++; $display("[TB] FAIL bh_sel1: got %0d expected 2", sel1O[0]); end
        nChecks++;
    endtask

    task automatic test_reset_mid_stall();
        doReset();
        setId(1, 1, 1, 0, 1, 4, 1);
        tick();
        setId(1, 1, 4, 0, 1, 6, 0);
        tick();
        rstN = 1'b0;
        modelReset();
        #1;
        if (stallO[2] !== 1'b0) begin nFails++; $display("[TB] FAIL rst_mid_stall: got %0d expected 0", stallO[2]); end
        nChecks++;
        if (bubO[2] !== 1'b1) begin nFails++; $display("[TB] FAIL rst_mid_bubble: got %0d expected 1", bubO[2]); end
        nChecks++;
        @(negedge clk);
        rstN = 1'b1;
        #1;
        if (stallO[2] !== 1'b0) begin nFails++; $display("[TB] FAIL rst_release_stall: got %0d expected 0", stallO[2]); end
        nChecks++;
        tick();
        if (bubO[2] !== 1'b0) begin nFails++; $display("[TB] FAIL rst_release_issue: got %0d expected 0", bubO[2]); end
        nChecks++;
    endtask

    task automatic test_zero_reg();
        doReset();
        setId(1, 1, 1, 0, 1, 0, 1);
        tick();
        setId(1, 0, 5, 0, 1, 6, 0);
        #1;
`ifdef ZERO_REG_EN
        if (stallO[0] !== 1'b0) begin nFails++; $display("[TB] FAIL zero_stall: got %0d expected 0", stallO[0]); end
        nChecks++;
        tick();
        if (sel1O[0] !== 2'd0) begin nFails++; $display("[TB] FAIL zero_sel1: got %0d expected 0", sel1O[0]); end
        nChecks++;
`else
        if (stallO[0] !== 1'b1) begin nFails++; $display("[TB] FAIL r0_stall: got %0d expected 1", stallO[0]); end
        nChecks++;
        tick();
`endif
    endtask

    task automatic test_imm();
        doReset();
        setId(1, 1, 1, 0, 1, 4, 1);
        tick();
        setId(1, 1, 4, 1, 1, 6, 0);
        #1;
        if (stallO[0] !== 1'b0) begin nFails++; $display("[TB] FAIL imm_no_stall: got %0d expected 0", stallO[0]); end
        nChecks++;
        tick();
        if (sel2O[0] !== 2'd3) begin nFails++; $display("[TB] FAIL imm_sel2: got %0d expected 3", sel2O[0]); end
        nChecks++;
    endtask

    task automatic test_random();
        doReset();
        for (int i = 0; i < 400; i++) begin
            setId($urandom_range(0, 9) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 4) != 0,
                  $urandom_range(0, 7), $urandom_range(0, 2) == 0);
            memBusy = ($urandom_range(0, 7) == 0);
            #1;
            for (int k = 0; k < NI; k++) begin
                if (stallO[k] !== mStall(k)) begin nFails++; $display("[TB] FAIL rnd_stall[%0d] cyc %0d: got %0d expected %0d", k, i, stallO[k], mStall(k)); end
                nChecks++;
                if (sel1O[k] !== mSel1[k]) begin nFails++; $display("[TB] FAIL rnd_sel1[%0d] cyc %0d: got %0d expected %0d", k, i, sel1O[k], mSel1[k]); end
                nChecks++;
                if (sel2O[k] !== mSel2[k]) begin nFails++; $display("[TB] FAIL rnd_sel2[%0d] cyc %0d: got %0d expected %0d", k, i, sel2O[k], mSel2[k]); end
                nChecks++;
                if (bubO[k] !== mBub[k]) begin nFails++; $display("[TB] FAIL rnd_bubble[%0d] cyc %0d: got %0d expected %0d", k, i, bubO[k], mBub[k]); end
                nChecks++;
            end
            tick();
        end
        memBusy = 1'b0;
    endtask

    initial begin
        rstN    = 1'b0;
        memBusy = 1'b0;
        setId(0, 0, 0, 0, 0, 0, 0);
        modelReset();
        $display("[TB] starting fwd_ctrl_unit bench");
        test_reset();
        test_forwarding();
        test_back_to_back();
        test_load_use();
        test_busy_hold();
        test_busy_hazard();
        test_reset_mid_stall();
        test_zero_reg();
        test_imm();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
